// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, FSM states and the
// EX/MEM control payload.
package exec_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTR_W = 4;

  localparam logic [CTR_W-1:0] ALU_ADD = 4'd0;
  localparam logic [CTR_W-1:0] ALU_SUB = 4'd1;
  localparam logic [CTR_W-1:0] ALU_AND = 4'd2;
  localparam logic [CTR_W-1:0] ALU_OR  = 4'd3;
  localparam logic [CTR_W-1:0] ALU_XOR = 4'd4;
  localparam logic [CTR_W-1:0] ALU_SLT = 4'd5;
  localparam logic [CTR_W-1:0] ALU_SLL = 4'd6;
  localparam logic [CTR_W-1:0] ALU_SRL = 4'd7;
  localparam logic [CTR_W-1:0] ALU_MUL = 4'd8;
  localparam logic [CTR_W-1:0] ALU_LUI = 4'd9;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } xm_ctl_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, one product bit per cycle,
// keeping the low WIDTH bits of the product.
module mul_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(ITER);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // done flags the final iteration so the owner can step on the same edge
  assign done    = busy_q && (cnt_q == CNT_W'(ITER - 1));
  assign busy    = busy_q;
  assign product = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative multiply with upstream stall,
// and the EX/MEM pipeline register.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_ITER = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             DX_MemtoReg,
  input  logic             DX_RegWrite,
  input  logic             DX_MemRead,
  input  logic             DX_MemWrite,
  input  logic             DX_ALUSrc,
  input  logic [3:0]       DX_ALUctr,
  input  logic [WIDTH-1:0] DX_A,
  input  logic [WIDTH-1:0] DX_B,
  input  logic [WIDTH-1:0] DX_imm,
  input  logic [4:0]       DX_RD,
  output logic             stall,
  output logic             XM_MemtoReg,
  output logic             XM_RegWrite,
  output logic             XM_MemRead,
  output logic             XM_MemWrite,
  output logic [WIDTH-1:0] ALUout,
  output logic [WIDTH-1:0] XM_MD,
  output logic [4:0]       XM_RD
);

  ex_state_e        state_q, state_d;
  xm_ctl_t          xm_ctl_q, xm_ctl_d, lat_ctl_q, lat_ctl_d, dx_ctl;
  logic [WIDTH-1:0] alu_out_q, alu_out_d, md_q, md_d, lat_md_q, lat_md_d;
  logic [4:0]       rd_q, rd_d, lat_rd_q, lat_rd_d;
  logic [WIDTH-1:0] op_b, alu_res, mul_product;
  logic             is_mul, mul_start, mul_busy, mul_done;

  assign dx_ctl    = {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite};
  assign op_b      = DX_ALUSrc ? DX_imm : DX_B;
  assign is_mul    = (DX_ALUctr == ALU_MUL);
  assign mul_start = (state_q == EX_IDLE) && is_mul;
  // stall depends only on state and opcode, and drops as soon as reset asserts
  assign stall     = rst_n && (mul_start || (state_q == EX_BUSY));

  always_comb begin
    alu_res = '0;
    case (DX_ALUctr)
      ALU_ADD: alu_res = DX_A + op_b;
      ALU_SUB: alu_res = DX_A - op_b;
      ALU_AND: alu_res = DX_A & op_b;
      ALU_OR:  alu_res = DX_A | op_b;
      ALU_XOR: alu_res = DX_A ^ op_b;
      ALU_SLT: alu_res = WIDTH'($signed(DX_A) < $signed(op_b));
      ALU_SLL: alu_res = DX_A << op_b[4:0];
      ALU_SRL: alu_res = DX_A >> op_b[4:0];
      ALU_LUI: alu_res = WIDTH'({op_b[15:0], 16'h0000});
      default: alu_res = '0;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH), .ITER(MUL_ITER)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (DX_A),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Sequencing of the EX/MEM register: pass-through, bubbles, multiply writeback
  always_comb begin
    state_d   = state_q;
    xm_ctl_d  = xm_ctl_q;
    alu_out_d = alu_out_q;
    md_d      = md_q;
    rd_d      = rd_q;
    lat_ctl_d = lat_ctl_q;
    lat_md_d  = lat_md_q;
    lat_rd_d  = lat_rd_q;
    case (state_q)
      EX_IDLE: begin
        if (is_mul) begin
          xm_ctl_d  = '0;
          lat_ctl_d = dx_ctl;
          lat_md_d  = DX_B;
          lat_rd_d  = DX_RD;
          state_d   = EX_BUSY;
        end else begin
          xm_ctl_d  = dx_ctl;
          alu_out_d = alu_res;
          md_d      = DX_B;
          rd_d      = DX_RD;
        end
      end
      EX_BUSY: begin
        xm_ctl_d = '0;
        if (mul_done)      state_d = EX_DONE;
        else if (!mul_busy) state_d = EX_IDLE;
      end
      EX_DONE: begin
        xm_ctl_d  = lat_ctl_q;
        alu_out_d = mul_product;
        md_d      = lat_md_q;
        rd_d      = lat_rd_q;
        state_d   = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EX_IDLE;
      xm_ctl_q  <= '0;
      alu_out_q <= '0;
      md_q      <= '0;
      rd_q      <= '0;
      lat_ctl_q <= '0;
      lat_md_q  <= '0;
      lat_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      xm_ctl_q  <= xm_ctl_d;
      alu_out_q <= alu_out_d;
      md_q      <= md_d;
      rd_q      <= rd_d;
      lat_ctl_q <= lat_ctl_d;
      lat_md_q  <= lat_md_d;
      lat_rd_q  <= lat_rd_d;
    end
  end

  assign XM_MemtoReg = xm_ctl_q.mem_to_reg;
  assign XM_RegWrite = xm_ctl_q.reg_write;
  assign XM_MemRead  = xm_ctl_q.mem_read;
  assign XM_MemWrite = xm_ctl_q.mem_write;
  assign ALUout      = alu_out_q;
  assign XM_MD       = md_q;
  assign XM_RD       = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, random ALU
// ops and multiplies against an arithmetic reference, reset mid-multiply.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_ALUSrc;
  logic [3:0]  DX_ALUctr;
  logic [31:0] DX_A, DX_B, DX_imm;
  logic [4:0]  DX_RD;
  logic        stall, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
  logic [31:0] ALUout, XM_MD;
  logic [4:0]  XM_RD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] m_alu;
  logic [4:0]  m_rd;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .DX_MemtoReg(DX_MemtoReg), .DX_RegWrite(DX_RegWrite),
    .DX_MemRead(DX_MemRead), .DX_MemWrite(DX_MemWrite),
    .DX_ALUSrc(DX_ALUSrc), .DX_ALUctr(DX_ALUctr),
    .DX_A(DX_A), .DX_B(DX_B), .DX_imm(DX_imm), .DX_RD(DX_RD),
    .stall(stall),
    .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
    .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
    .ALUout(ALUout), .XM_MD(XM_MD), .XM_RD(XM_RD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ctl;
    logic        src;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl, input logic src, input logic [3:0] op,
                              input logic [31:0] a, b, imm, input logic [4:0] rd,
                              input logic [31:0] exp);
    vec_t v;
    v.ctl = ctl; v.src = src; v.op = op; v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  // Reference ALU straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return a * b;
      4'd9: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xm_ctl();
    return 32'({XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite});
  endfunction

  task automatic drive(input logic [3:0] ctl, input logic src, input logic [3:0] op,
                       input logic [31:0] a, b, imm, input logic [4:0] rd);
    {DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite} = ctl;
    DX_ALUSrc = src; DX_ALUctr = op; DX_A = a; DX_B = b; DX_imm = imm; DX_RD = rd;
  endtask

  // Single-cycle op: present at a negedge, result after the next rising edge
  task automatic run_op(input vec_t v, input string name);
    drive(v.ctl, v.src, v.op, v.a, v.b, v.imm, v.rd);
    #1 chk({name, " stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({name, " alu"}, ALUout, v.exp);
    chk({name, " md"}, XM_MD, v.b);
    chk({name, " rd"}, 32'(XM_RD), 32'(v.rd));
    chk({name, " ctl"}, xm_ctl(), 32'(v.ctl));
    m_alu = v.exp; m_rd = v.rd;
  endtask

  // Multiply: 33 stalled cycles of bubbles, then the product after the DONE edge
  task automatic run_mul(input logic [31:0] a, b, input logic src, input logic [31:0] imm,
                         input logic [3:0] ctl, input logic [4:0] rd, output int done_cyc);
    int n;
    logic [31:0] exp;
    exp = ref_alu(ALU_MUL, a, src ? imm : b);
    drive(ctl, src, ALU_MUL, a, b, imm, rd);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      if (n > 0) begin
        chk("mul bubble ctl", xm_ctl(), 32'd0);
        chk("mul hold alu", ALUout, m_alu);
        chk("mul hold rd", 32'(XM_RD), 32'(m_rd));
      end
      n++;
      @(negedge clk);
    end
    chk("mul stall cycles", 32'(n), 32'd33);
    @(negedge clk);
    chk("mul product", ALUout, exp);
    chk("mul rd", 32'(XM_RD), 32'(rd));
    chk("mul md", XM_MD, b);
    chk("mul ctl", xm_ctl(), 32'(ctl));
    done_cyc = cyc;
    m_alu = exp; m_rd = rd;
  endtask

  vec_t vt[13];

  initial begin
    int c1, c2;
    int n;
    vec_t v;

    vt[0]  = mk(4'b0100, 1'b0, ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd3, 32'h80000000);
    vt[1]  = mk(4'b0100, 1'b0, ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd4, 32'h1);
    vt[2]  = mk(4'b0100, 1'b0, ALU_SUB, 32'd5, 32'd7, 32'h0, 5'd5, 32'hFFFFFFFE);
    vt[3]  = mk(4'b0100, 1'b1, ALU_ADD, 32'd4, 32'd999, 32'h10, 5'd6, 32'h14);
    vt[4]  = mk(4'b0001, 1'b1, ALU_ADD, 32'h20, 32'hDEADBEEF, 32'h4, 5'd0, 32'h24);
    vt[5]  = mk(4'b0100, 1'b0, ALU_SLL, 32'h1, 32'd31, 32'h0, 5'd7, 32'h80000000);
    vt[6]  = mk(4'b0100, 1'b0, ALU_SRL, 32'h80000000, 32'h24, 32'h0, 5'd8, 32'h08000000);
    vt[7]  = mk(4'b0100, 1'b1, ALU_LUI, 32'h0, 32'h5, 32'h1234ABCD, 5'd10, 32'hABCD0000);
    vt[8]  = mk(4'b0100, 1'b0, 4'd12, 32'h1234, 32'h5678, 32'h0, 5'd11, 32'h0);
    vt[9]  = mk(4'b0100, 1'b0, ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 5'd12, 32'h0FF00FF0);
    vt[10] = mk(4'b0100, 1'b0, ALU_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd13, 32'h0);
    vt[11] = mk(4'b0100, 1'b0, ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 5'd14, 32'h0F0F0000);
    vt[12] = mk(4'b1110, 1'b1, ALU_ADD, 32'h100, 32'h1, 32'hFFFFFFFC, 5'd15, 32'hFC);

    drive(4'b0000, 1'b0, ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    chk("reset alu", ALUout, 32'h0);
    chk("reset md", XM_MD, 32'h0);
    chk("reset rd", 32'(XM_RD), 32'h0);
    chk("reset ctl", xm_ctl(), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    m_alu = 32'h0; m_rd = 5'd0;

    for (int i = 0; i < 13; i++) run_op(vt[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++) begin
      v.op = 4'($urandom_range(15));
      if (v.op == ALU_MUL) v.op = ALU_SUB;
      v.ctl = 4'($urandom); v.src = 1'($urandom); v.rd = 5'($urandom);
      v.a = $urandom; v.b = $urandom; v.imm = $urandom;
      v.exp = ref_alu(v.op, v.a, v.src ? v.imm : v.b);
      run_op(v, $sformatf("rand%0d op%0d", i, v.op));
    end

    run_mul(32'd7, 32'd6, 1'b0, 32'h0, 4'b0100, 5'd9, c1);
    run_mul(32'hFFFFFFFF, 32'd2, 1'b0, 32'h0, 4'b0100, 5'd2, c1);
    run_mul($urandom, $urandom, 1'b0, $urandom, 4'($urandom), 5'($urandom), c1);
    run_mul($urandom, 32'h1234, 1'b1, $urandom, 4'b0100, 5'd17, c1);
    run_mul(32'd3, 32'd5, 1'b0, 32'h0, 4'b0100, 5'd20, c1);
    run_mul(32'h10001, 32'hFFFF, 1'b0, 32'h0, 4'b0100, 5'd21, c2);
    chk("b2b mul spacing", 32'(c2 - c1), 32'd34);
    run_op(vt[0], "post mul add");

    // reset pulsed during BUSY cycle 10
    drive(4'b0100, 1'b0, ALU_MUL, 32'd123, 32'd456, 32'h0, 5'd9);
    n = 0;
    while (n < 11) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("rst mid alu", ALUout, 32'h0);
    chk("rst mid md", XM_MD, 32'h0);
    chk("rst mid rd", 32'(XM_RD), 32'h0);
    chk("rst mid ctl", xm_ctl(), 32'h0);
    chk("rst mid stall", 32'(stall), 32'h0);
    drive(4'b0100, 1'b0, ALU_ADD, 32'd1, 32'd1, 32'h0, 5'd5);
    @(negedge clk);
    chk("rst held alu", ALUout, 32'h0);
    rst_n = 1'b1;
    #1 chk("post rst stall", 32'(stall), 32'h0);
    @(negedge clk);
    chk("post rst add", ALUout, 32'd2);
    chk("post rst rd", 32'(XM_RD), 32'd5);
    chk("post rst ctl", xm_ctl(), 32'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipeline, sitting between the ID/EX register and the memory stage. It performs single-cycle ALU operations and an iterative 32-cycle multiply, then registers the result and control bits into the EX/MEM pipeline register (XM_*, ALUout, XM_MD) that the memory stage consumes. During a multiply it stalls upstream and inserts bubbles downstream.

## Interface
Parameters:
- WIDTH, 32, datapath width; the only supported value is 32.
- MUL_ITER, 32, multiplier iterations, one product bit per cycle.

Ports:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  reset, asynchronous and active-low.
- DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite  in  1 each  control bits from ID/EX.
- DX_ALUSrc  in  1  selects the B operand: 1 = DX_imm, 0 = DX_B.
- DX_ALUctr  in  4  operation code.
- DX_A, DX_B, DX_imm  in  32 each  operands; DX_B is also the store data.
- DX_RD  in  5  destination register.
- stall  out  1  combinational; while high, upstream holds every DX_* input stable.
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite  out  1 each  registered control bits.
- ALUout  out  32  registered result; also the memory address.
- XM_MD  out  32  registered store data (DX_B).
- XM_RD  out  5  registered destination register.

## Operation
- Operand selection: opB = DX_ALUSrc ? DX_imm : DX_B.
- Operation codes:
  - 0 ADD, 1 SUB: both wrap modulo 2^32.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLT: signed compare, result is 1 or 0.
  - 6 SLL, 7 SRL: logical shift of A by opB[4:0].
  - 8 MUL: low 32 bits of A×opB.
  - 9 LUI: {opB[15:0], 16'b0}.
  - 10–15: result 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-MUL op:
  - stall = 0.
  - At the clock edge, the XM_* registers load the DX_* control bits, ALUout = result, XM_MD = DX_B, XM_RD = DX_RD.
- IDLE, MUL op:
  - stall = 1.
  - Multiplicand and multiplier are captured into the sub-module, and the captured copies are used from then on.
  - The destination and control bits are latched internally.
  - A bubble is written to EX/MEM: all four XM control bits = 0; ALUout, XM_MD and XM_RD keep their previous values.
  - The FSM moves to BUSY with cnt = 0.
- BUSY:
  - stall = 1; a bubble is written every cycle.
  - One shift-add iteration per cycle.
  - When cnt = MUL_ITER−1, the FSM moves to DONE; otherwise cnt increments.
- DONE:
  - stall = 0.
  - EX/MEM loads the latched control bits, ALUout = product, XM_MD = latched B, XM_RD = latched RD.
  - The FSM returns to IDLE.
  - The ID/EX register advances on this same edge, so the next instruction is presented in the following cycle.
- Back-to-back MUL instructions re-enter BUSY through IDLE; there is no overlap between them.
- Reset, asserted at any time including mid-multiply:
  - All outputs and registers go to 0 immediately; the FSM goes to IDLE, cnt = 0, stall = 0.
  - An in-flight multiply is discarded.
- No forwarding is done in this block; forwarding is resolved upstream.

## Timing
- Non-MUL latency: 1 cycle. An input at edge k appears on the outputs after edge k+1.
- MUL, presented in cycle t0:
  - stall is high for cycles t0 through t0+32 (33 cycles), and EX/MEM holds a bubble during that time.
  - DONE is cycle t0+33; the product is visible on ALUout after its edge.
- stall depends on the FSM state and DX_ALUctr only; it has no path through the operand values.
- Reset values: XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite = 0; ALUout = 0; XM_MD = 0; XM_RD = 0; stall = 0.

## Structure
- Shared package exec_pkg holds:
  - ALU operation-code localparams ALU_ADD through ALU_LUI.
  - FSM state encodings EX_IDLE, EX_BUSY, EX_DONE.
- Sub-module mul_iter:
  - Ports: start, a, b, busy, done, product.
  - Implements an unsigned shift-add multiply keeping the low 32 bits, with a 5-bit counter.
- execute_stage contains the ALU combinational logic, the FSM and the EX/MEM register.

## Test plan
- ADD, A = 0x7FFFFFFF, opB = 1 → ALUout = 0x80000000 one cycle later; control bits pass through; stall stays 0.
- SLT, A = 0xFFFFFFFF, B = 1 → 1. SUB 5−7 → 0xFFFFFFFE. ALUSrc = 1 with imm = 0x10 and ADD A = 4 → 0x14.
- Store: MemWrite = 1, A = 0x20, imm = 4, B = 0xDEADBEEF → ALUout = 0x24, XM_MD = 0xDEADBEEF, XM_MemWrite = 1.
- MUL 7×6 with RegWrite = 1, RD = 9:
  - stall is high for exactly 33 cycles, with XM_RegWrite = 0 during that time.
  - Then ALUout = 42, XM_RD = 9, XM_RegWrite = 1.
- MUL 0xFFFFFFFF×2 → 0xFFFFFFFE. Two consecutive MULs → two results 34 cycles apart.
- rst_n pulsed low at BUSY cycle 10 → all outputs 0 at once, stall = 0; the next ADD 1+1 → 2 with normal latency.
